// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle control sequencer:
// opcodes, FSM states, ALU and PC-select codes, decode bundle.
package cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6;
    localparam logic [3:0] OP_LD   = 4'h7;
    localparam logic [3:0] OP_ST   = 4'h8;
    localparam logic [3:0] OP_BEQ  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;

    localparam logic [1:0] PC_INC = 2'd0;
    localparam logic [1:0] PC_BR  = 2'd1;
    localparam logic [1:0] PC_JMP = 2'd2;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       alu_src_b;
        logic       is_mem;
        logic       is_store;
        logic       is_branch;
        logic       needs_wb;
    } dec_t;

    // HALT reports as the DECODE phase on the 2-bit phase bus
    function automatic logic [1:0] phase_of(state_t s);
        case (s)
            S_DECODE: phase_of = 2'd1;
            S_EXEC:   phase_of = 2'd2;
            S_WB:     phase_of = 2'd3;
            S_HALT:   phase_of = 2'd1;
            default:  phase_of = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_control_fsm_if.sv
// Control bundle between the sequencer (master) and the
// passive datapath/memory side (slave).
interface cpu_control_fsm_if #(
    parameter int OPW = 4
);
    logic [OPW-1:0] ir_op;
    logic           mem_ready;
    logic           alu_zero;
    logic           step;
    logic           mem_req;
    logic           mem_we;
    logic           addr_sel;
    logic           ir_load;
    logic           pc_en;
    logic [1:0]     pc_sel;
    logic [2:0]     alu_op;
    logic           alu_src_b;
    logic           reg_we;
    logic           wb_sel;
    logic [1:0]     cur;
    logic           halted;
    logic           bus_err;

    modport master (
        input  ir_op, mem_ready, alu_zero, step,
        output mem_req, mem_we, addr_sel, ir_load,
        output pc_en, pc_sel, alu_op, alu_src_b,
        output reg_we, wb_sel, cur, halted, bus_err
    );

    modport slave (
        output ir_op, mem_ready, alu_zero, step,
        input  mem_req, mem_we, addr_sel, ir_load,
        input  pc_en, pc_sel, alu_op, alu_src_b,
        input  reg_we, wb_sel, cur, halted, bus_err
    );
endinterface

// File: rtl/cpu_decode.sv
// Combinational opcode classifier feeding the sequencer.
// Illegal opcodes decode to all-zero, i.e. behave as NOP.
module cpu_decode
    import cpu_pkg::*;
#(
    parameter int OPW = 4
) (
    input  logic [OPW-1:0] op,
    output dec_t           dec
);
    logic [3:0] o;
    assign o = 4'(op);

    always_comb begin
        dec = '0;
        unique case (1'b1)
            o == OP_ADD: begin
                dec.alu_op   = ALU_ADD;
                dec.needs_wb = 1'b1;
            end
            o == OP_SUB: begin
                dec.alu_op   = ALU_SUB;
                dec.needs_wb = 1'b1;
            end
            o == OP_AND: begin
                dec.alu_op   = ALU_AND;
                dec.needs_wb = 1'b1;
            end
            o == OP_OR: begin
                dec.alu_op   = ALU_OR;
                dec.needs_wb = 1'b1;
            end
            o == OP_XOR: begin
                dec.alu_op   = ALU_XOR;
                dec.needs_wb = 1'b1;
            end
            o == OP_ADDI: begin
                dec.alu_op    = ALU_ADD;
                dec.alu_src_b = 1'b1;
                dec.needs_wb  = 1'b1;
            end
            o == OP_LD: begin
                dec.alu_op    = ALU_ADD;
                dec.alu_src_b = 1'b1;
                dec.is_mem    = 1'b1;
                dec.needs_wb  = 1'b1;
            end
            o == OP_ST: begin
                dec.alu_op    = ALU_ADD;
                dec.alu_src_b = 1'b1;
                dec.is_mem    = 1'b1;
                dec.is_store  = 1'b1;
            end
            o == OP_BEQ: begin
                dec.alu_op    = ALU_SUB;
                dec.is_branch = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/cpu_control_fsm.sv
// Multicycle fetch/decode/execute/writeback sequencer with memory watchdog.
// Define CPU_CTRL_STEP_EN to gate each instruction fetch on a step pulse.
module cpu_control_fsm #(
    parameter int MEM_TIMEOUT = 15,
    parameter int OPW         = 4
) (
    input logic               clk,
    input logic               rst,
    cpu_control_fsm_if.master bus
);
    import cpu_pkg::*;

    localparam logic [3:0] TMO   = 4'(MEM_TIMEOUT);
    localparam logic       WD_EN = (MEM_TIMEOUT != 0);

    state_t     state;
    logic [3:0] wcnt;
    logic [3:0] wcnt_nxt;
    logic       err_q;
    dec_t       dec;
    logic       run;
    logic       waiting;
    logic       expire;
    logic       accept;
    logic       go_exec;

    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       ir_load;
    logic       pc_en;
    logic [1:0] pc_sel;
    logic [2:0] alu_op;
    logic       alu_src_b;
    logic       reg_we;
    logic       wb_sel;

    cpu_decode #(.OPW(OPW)) u_dec (
        .op  (bus.ir_op),
        .dec (dec)
    );

`ifdef CPU_CTRL_STEP_EN
    logic step_q;
    logic go;
    assign run = go;
`else
    logic unused_step;
    assign unused_step = bus.step;
    assign run = 1'b1;
`endif

    assign wcnt_nxt = (wcnt == 4'hF) ? wcnt : wcnt + 4'd1;
    assign accept   = mem_req & bus.mem_ready;
    assign waiting  = mem_req & ~bus.mem_ready;
    // a ready arriving on the expiry cycle still completes the access
    assign expire   = WD_EN & waiting & (wcnt_nxt == TMO);
    assign go_exec  = dec.needs_wb | dec.is_store | dec.is_branch;

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_load   = 1'b0;
        pc_en     = 1'b0;
        pc_sel    = PC_INC;
        alu_op    = ALU_ADD;
        alu_src_b = 1'b0;
        reg_we    = 1'b0;
        wb_sel    = 1'b0;
        if (!rst) begin
            unique case (state)
                S_FETCH: begin
                    mem_req = run;
                    ir_load = run & bus.mem_ready;
                    pc_en   = run & bus.mem_ready;
                end
                S_DECODE: begin
                    if (4'(bus.ir_op) == OP_JMP) begin
                        pc_en  = 1'b1;
                        pc_sel = PC_JMP;
                    end
                end
                S_EXEC: begin
                    alu_op    = dec.alu_op;
                    alu_src_b = dec.alu_src_b;
                    mem_req   = dec.is_mem;
                    addr_sel  = dec.is_mem;
                    mem_we    = dec.is_store;
                    if (dec.is_branch && bus.alu_zero) begin
                        pc_en  = 1'b1;
                        pc_sel = PC_BR;
                    end
                end
                S_WB: begin
                    alu_op    = dec.alu_op;
                    alu_src_b = dec.alu_src_b;
                    reg_we    = 1'b1;
                    wb_sel    = dec.is_mem;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
            wcnt  <= 4'd0;
            err_q <= 1'b0;
`ifdef CPU_CTRL_STEP_EN
            step_q <= 1'b0;
            go     <= 1'b0;
`endif
        end else begin
            if (accept || expire)
                wcnt <= 4'd0;
            else if (waiting)
                wcnt <= wcnt_nxt;
            if (expire)
                err_q <= 1'b1;
            unique case (state)
                S_FETCH: begin
                    if (accept)
                        state <= S_DECODE;
                    else if (expire)
                        state <= S_HALT;
                end
                S_DECODE: begin
                    unique case (1'b1)
                        4'(bus.ir_op) == OP_HLT: state <= S_HALT;
                        go_exec:                 state <= S_EXEC;
                        default:                 state <= S_FETCH;
                    endcase
                end
                S_EXEC: begin
                    if (dec.is_mem) begin
                        if (bus.mem_ready)
                            state <= dec.is_store ? S_FETCH : S_WB;
                        else if (expire)
                            state <= S_HALT;
                    end else if (dec.is_branch) begin
                        state <= S_FETCH;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_WB:    state <= S_FETCH;
                S_HALT:  state <= S_HALT;
                default: state <= S_FETCH;
            endcase
`ifdef CPU_CTRL_STEP_EN
            // only an edge seen while idling in FETCH arms one fetch
            step_q <= bus.step;
            if (state == S_FETCH && !go && bus.step && !step_q)
                go <= 1'b1;
            else if (state == S_FETCH && accept)
                go <= 1'b0;
`endif
        end
    end

    assign bus.mem_req   = mem_req;
    assign bus.mem_we    = mem_we;
    assign bus.addr_sel  = addr_sel;
    assign bus.ir_load   = ir_load;
    assign bus.pc_en     = pc_en;
    assign bus.pc_sel    = pc_sel;
    assign bus.alu_op    = alu_op;
    assign bus.alu_src_b = alu_src_b;
    assign bus.reg_we    = reg_we;
    assign bus.wb_sel    = wb_sel;
    assign bus.cur       = phase_of(state);
    assign bus.halted    = (state == S_HALT);
    assign bus.bus_err   = err_q;
endmodule
